// File: rtl/fir_pkg.sv
// fir_pkg -- shared definitions for the L-parallel FIR.
//   NTAPS_MAX / CW_MAX : bounds of the default coefficient table
//   coef_t, coef_tab_t : coefficient word and full-table array types
//   DEF_COEF           : reset coefficient table, h[j] = (j odd) ? -(j+1) : j+1
//   fir_aw()           : full-precision accumulator width DW+CW+clog2(NTAPS)
package fir_pkg;

  localparam int NTAPS_MAX = 64;
  localparam int CW_MAX    = 16;

  typedef logic [CW_MAX-1:0]                  coef_t;
  typedef logic [NTAPS_MAX-1:0][CW_MAX-1:0]   coef_tab_t;

  function automatic coef_tab_t build_def_coef();
    coef_tab_t t;
    t = '0;
    for (int unsigned j = 0; j < NTAPS_MAX; j++) begin
      t[j] = (j % 2 == 1) ? -coef_t'(j + 1) : coef_t'(j + 1);
    end
    return t;
  endfunction

  localparam coef_tab_t DEF_COEF = build_def_coef();

  function automatic int fir_aw(input int dw, input int cw, input int ntaps);
    return dw + cw + $clog2(ntaps);
  endfunction

endpackage

// File: rtl/fir_lane_mac.sv
// fir_lane_mac -- one output lane: registered products, then an adder tree.
//   clk, rst : clock, asynchronous active-high reset
//   x        : NTAPS signed samples, x[j] multiplies h[j]
//   h        : NTAPS signed coefficients
//   acc      : full-precision signed sum of the registered products (AW bits)
module fir_lane_mac #(
  parameter int NTAPS = 16,
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int AW    = 36
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NTAPS-1:0][DW-1:0]   x,
  input  logic [NTAPS-1:0][CW-1:0]   h,
  output logic [AW-1:0]              acc
);

  logic signed [DW+CW-1:0] prod_q [NTAPS];
  logic signed [DW+CW-1:0] prod_d [NTAPS];

  always_comb begin
    for (int unsigned j = 0; j < NTAPS; j++) begin
      prod_d[j] = $signed(x[j]) * $signed(h[j]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned j = 0; j < NTAPS; j++) prod_q[j] <= '0;
    end else begin
      for (int unsigned j = 0; j < NTAPS; j++) prod_q[j] <= prod_d[j];
    end
  end

  // Products are sign-extended to AW before summing, so no bits are lost.
  always_comb begin
    acc = '0;
    for (int unsigned j = 0; j < NTAPS; j++) begin
      acc = acc + AW'(prod_q[j]);
    end
  end

endmodule

// File: rtl/l_parallel_fir.sv
// l_parallel_fir -- L-samples-per-clock FIR, 3-stage pipeline, latency 3.
//   clk, rst   : clock, asynchronous active-high reset
//   din        : L signed samples, lane 0 oldest;  in_valid qualifies din
//   coef_we    : write coef_data into h[coef_idx] (idx >= NTAPS ignored)
//   dout       : L signed outputs, lane i <-> din lane i; held while out_valid=0
//   out_valid  : in_valid delayed by 3 cycles
// Optional feature: define FIR_OUT_SAT_EN to clamp dout when OW < AW
// (otherwise dout wraps to the low OW bits of the accumulator).
module l_parallel_fir
  import fir_pkg::*;
#(
  parameter int L     = 2,
  parameter int NTAPS = 16,
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int OW    = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [L-1:0][DW-1:0]        din,
  input  logic                        in_valid,
  input  logic                        coef_we,
  input  logic [$clog2(NTAPS)-1:0]    coef_idx,
  input  logic [CW-1:0]               coef_data,
  output logic [L-1:0][OW-1:0]        dout,
  output logic                        out_valid
);

  localparam int AW = fir_aw(DW, CW, NTAPS);
  localparam int WN = NTAPS + L - 1;

  // win_q is newest-first: win_q[0] = newest sample, and its first NTAPS-1
  // entries double as the delay line for the next block.
  logic [WN-1:0][DW-1:0]          win_q, win_d;
  logic [NTAPS-1:0][CW-1:0]       h_q, h_d;
  logic [NTAPS-1:0][CW-1:0]       hs_q, hs_d;
  logic                           v1_q, v1_d, v2_q, v2_d, ov_q, ov_d;
  logic [L-1:0][OW-1:0]           dout_q, dout_d;
  logic [L-1:0][NTAPS-1:0][DW-1:0] lane_x;
  logic [L-1:0][AW-1:0]           lane_acc;
  logic [L-1:0][OW-1:0]           lane_red;

  always_comb begin
    h_d = h_q;
    if (coef_we && (32'(coef_idx) < NTAPS)) h_d[coef_idx] = coef_data;

    // hs_q snapshots h_q with each block so a same-edge write is not seen
    // by the block being captured, only by the following one.
    win_d = win_q;
    hs_d  = hs_q;
    if (in_valid) begin
      for (int unsigned i = 0; i < L; i++) win_d[i] = din[L - 1 - i];
      for (int unsigned n = 0; n < NTAPS - 1; n++) win_d[L + n] = win_q[n];
      hs_d = h_q;
    end

    v1_d   = in_valid;
    v2_d   = v1_q;
    ov_d   = v2_q;
    dout_d = v2_q ? lane_red : dout_q;
  end

  // Lane i output y(kL+i) needs x(kL+i-j), which sits at win_q[L-1-i+j].
  always_comb begin
    for (int unsigned i = 0; i < L; i++) begin
      for (int unsigned j = 0; j < NTAPS; j++) begin
        lane_x[i][j] = win_q[L - 1 - i + j];
      end
    end
  end

  for (genvar g = 0; g < L; g++) begin : g_lane
    fir_lane_mac #(
      .NTAPS (NTAPS),
      .DW    (DW),
      .CW    (CW),
      .AW    (AW)
    ) u_mac (
      .clk (clk),
      .rst (rst),
      .x   (lane_x[g]),
      .h   (hs_q),
      .acc (lane_acc[g])
    );

    if (OW >= AW) begin : g_ext
      always_comb lane_red[g] = OW'($signed(lane_acc[g]));
    end else begin : g_red
`ifdef FIR_OUT_SAT_EN
      // In range iff all bits from the OW-1 sign position upward agree.
      logic in_rng;
      always_comb begin
        in_rng = (&lane_acc[g][AW-1:OW-1]) || !(|lane_acc[g][AW-1:OW-1]);
        if (in_rng)                lane_red[g] = lane_acc[g][OW-1:0];
        else if (lane_acc[g][AW-1]) lane_red[g] = {1'b1, {(OW-1){1'b0}}};
        else                        lane_red[g] = {1'b0, {(OW-1){1'b1}}};
      end
`else
      always_comb lane_red[g] = lane_acc[g][OW-1:0];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q  <= '0;
      hs_q   <= '0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      ov_q   <= 1'b0;
      dout_q <= '0;
      for (int unsigned j = 0; j < NTAPS; j++) h_q[j] <= CW'($signed(DEF_COEF[j]));
    end else begin
      win_q  <= win_d;
      hs_q   <= hs_d;
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      ov_q   <= ov_d;
      dout_q <= dout_d;
      h_q    <= h_d;
    end
  end

  always_comb begin
    dout      = dout_q;
    out_valid = ov_q;
  end

endmodule
